// File: rtl/regfile_param_sb.sv
// Purpose : multi-read-port GPR file with x0 hardwired to zero, optional write->read
//           bypass, a post-reset clear sequencer and a per-register pending scoreboard.
// Latency : reads are combinational (0 cycles); writes/reserves take effect at the next rising edge.
// Backpressure: none inside the block; busy[i] tells decode to stall on a RAW hazard.
// Ports   : clk/rst_n (async active-low); init_done high once the clear sequence ends;
//           we/waddr/wdata writeback port; raddr/rdata packed read ports (port i at slice i);
//           rsv_en/rsv_addr mark a destination pending; busy[i] = port i reads a pending reg.
module regfile_param_sb #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_done,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [XLEN-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]   raddr,
  output logic [NUM_RD*XLEN-1:0] rdata,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic [NUM_RD-1:0]      busy
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [XLEN-1:0]   mem_wd;
  logic              run;

  assign run       = (state_q == ST_RUN);
  assign init_done = run;

  // Sequencer and storage write port: INIT owns the write port, RUN hands it to writeback.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_wa    = waddr;
    mem_wd    = wdata;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        mem_wa = clr_ptr_q;
        mem_wd = '0;
        // Hold the pointer on the last entry so it never wraps back to 0.
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          clr_ptr_d = clr_ptr_q + AW'(1);
        end
      end
      ST_RUN: begin
        mem_we = we && (waddr != '0);
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Scoreboard: the reserve is applied after the release so set wins over clear.
  always_comb begin
    pend_d = pend_q;
    if (run) begin
      if (we) begin
        pend_d[waddr] = 1'b0;
      end
      if (rsv_en) begin
        pend_d[rsv_addr] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= AW'(1);
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      pend_q    <= pend_d;
    end
  end

  // Storage has no reset; the clear sequencer zeroes it. Entry 0 is never read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  // Read ports and hazard flags. While clearing, everything reads as zero / not busy.
  always_comb begin
    logic [AW-1:0] ra;
    logic          fwd;
    rdata = '0;
    busy  = '0;
    ra    = '0;
    fwd   = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = raddr[i*AW +: AW];
      fwd = BYPASS && we && (waddr == ra);
      if (run && (ra != '0)) begin
        rdata[i*XLEN +: XLEN] = fwd ? wdata : mem_q[ra];
        busy[i]               = pend_q[ra] && !fwd;
      end
    end
  end

endmodule

// File: tb/tb_regfile_param_sb.sv
module tb_regfile_param_sb;

  logic         clk;
  logic         rst_n;

  // Shared stimulus for the two default-size instances (BYPASS=1 and BYPASS=0).
  logic         we;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [9:0]   raddr;
  logic         rsv_en;
  logic [4:0]   rsv_addr;
  logic [63:0]  rdata_a, rdata_b;
  logic [1:0]   busy_a, busy_b;
  logic         init_done_a, init_done_b;

  // Stimulus for the 3-port, 16-entry, 64-bit instance.
  logic         we_c;
  logic [3:0]   waddr_c;
  logic [63:0]  wdata_c;
  logic [11:0]  raddr_c;
  logic         rsv_en_c;
  logic [3:0]   rsv_addr_c;
  logic [191:0] rdata_c;
  logic [2:0]   busy_c;
  logic         init_done_c;

  regfile_param_sb #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_done(init_done_a),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_a),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_a));

  regfile_param_sb #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_done(init_done_b),
    .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy_b));

  regfile_param_sb #(.XLEN(64), .DEPTH(16), .NUM_RD(3), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .init_done(init_done_c),
    .we(we_c), .waddr(waddr_c), .wdata(wdata_c), .raddr(raddr_c), .rdata(rdata_c),
    .rsv_en(rsv_en_c), .rsv_addr(rsv_addr_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents and pending flags.
  logic [31:0] mem_ab [32];
  logic        pend_ab [32];
  logic [63:0] mem_c [16];
  logic        pend_c [16];
  int          cyc;       // rising edges since reset release
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_models();
    for (int r = 0; r < 32; r++) begin
      mem_ab[r]  = '0;
      pend_ab[r] = 1'b0;
    end
    for (int r = 0; r < 16; r++) begin
      mem_c[r]  = '0;
      pend_c[r] = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic idle_all();
    we = 1'b0; waddr = '0; wdata = '0; raddr = '0; rsv_en = 1'b0; rsv_addr = '0;
    we_c = 1'b0; waddr_c = '0; wdata_c = '0; raddr_c = '0; rsv_en_c = 1'b0; rsv_addr_c = '0;
  endtask

  // Called at a falling edge; releases reset at a falling edge n cycles later.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle_all();
    #1;
    chk("init_done_a_async_rst", init_done_a, 1'b0);
    chk("init_done_c_async_rst", init_done_c, 1'b0);
    repeat (n) @(negedge clk);
    clear_models();
    rst_n = 1'b1;
  endtask

  task automatic step_ab(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic rs, input logic [4:0] rsa);
    bit          run;
    bit          fwd;
    logic [4:0]  ra;
    logic [31:0] exp_d;
    logic        exp_b;
    we = w; waddr = wa; wdata = wd; raddr = {r1, r0}; rsv_en = rs; rsv_addr = rsa;
    we_c = 1'b0; rsv_en_c = 1'b0;
    #1;
    run = (cyc >= 31);
    chk("init_done_a", init_done_a, run);
    chk("init_done_b", init_done_b, run);
    chk("init_done_c", init_done_c, cyc >= 15);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        ra    = (p == 0) ? r0 : r1;
        fwd   = (d == 0) && w && (wa == ra);
        exp_d = (!run || ra == 0) ? 32'h0 : (fwd ? wd : mem_ab[ra]);
        exp_b = run && (ra != 0) && pend_ab[ra] && !fwd;
        if (d == 0) begin
          chk($sformatf("rdata%0d_byp", p), rdata_a[p*32 +: 32], exp_d);
          chk($sformatf("busy%0d_byp", p), busy_a[p], exp_b);
        end else begin
          chk($sformatf("rdata%0d_nobyp", p), rdata_b[p*32 +: 32], exp_d);
          chk($sformatf("busy%0d_nobyp", p), busy_b[p], exp_b);
        end
      end
    end
    @(posedge clk);
    if (run) begin
      if (w && wa != 0) mem_ab[wa] = wd;
      if (w) pend_ab[wa] = 1'b0;
      if (rs && rsa != 0) pend_ab[rsa] = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step_c(input logic w, input logic [3:0] wa, input logic [63:0] wd,
                        input logic [11:0] ra_all, input logic rs, input logic [3:0] rsa);
    bit          run;
    bit          fwd;
    logic [3:0]  ra;
    logic [63:0] exp_d;
    logic        exp_b;
    we_c = w; waddr_c = wa; wdata_c = wd; raddr_c = ra_all; rsv_en_c = rs; rsv_addr_c = rsa;
    we = 1'b0; rsv_en = 1'b0;
    #1;
    run = (cyc >= 15);
    chk("init_done_c", init_done_c, run);
    for (int p = 0; p < 3; p++) begin
      ra    = ra_all[p*4 +: 4];
      fwd   = w && (wa == ra);
      exp_d = (!run || ra == 0) ? 64'h0 : (fwd ? wd : mem_c[ra]);
      exp_b = run && (ra != 0) && pend_c[ra] && !fwd;
      chk($sformatf("c_rdata%0d", p), rdata_c[p*64 +: 64], exp_d);
      chk($sformatf("c_busy%0d", p), busy_c[p], exp_b);
    end
    @(posedge clk);
    if (run) begin
      if (w && wa != 0) mem_c[wa] = wd;
      if (w) pend_c[wa] = 1'b0;
      if (rs && rsa != 0) pend_c[rsa] = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Addresses biased toward a small window so hazards collide often.
  function automatic logic [4:0] rnd_a5();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [3:0] rnd_a4();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
  endfunction

  task automatic rand_ab();
    step_ab(1'($urandom_range(0, 1)), rnd_a5(), $urandom, rnd_a5(), rnd_a5(),
            ($urandom_range(0, 3) == 0), rnd_a5());
  endtask

  task automatic rand_c();
    step_c(1'($urandom_range(0, 1)), rnd_a4(), {$urandom, $urandom},
           {rnd_a4(), rnd_a4(), rnd_a4()}, ($urandom_range(0, 3) == 0), rnd_a4());
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_all();
    clear_models();
    @(negedge clk);
    do_reset(3);

    // Clear sequence: traffic during INIT is ignored, reads stay zero.
    repeat (33) rand_ab();
    for (int r = 0; r < 32; r += 2) step_ab(1'b0, 5'd0, 32'h0, 5'(r), 5'(r + 1), 1'b0, 5'd0);

    // Write then read back; writes to x0 are dropped.
    step_ab(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0);
    step_ab(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
    step_ab(1'b1, 5'd0, 32'hCAFEF00D, 5'd0, 5'd5, 1'b0, 5'd0);
    step_ab(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);

    // Same-cycle forwarding versus stored value.
    step_ab(1'b1, 5'd7, 32'h00001234, 5'd0, 5'd7, 1'b0, 5'd0);
    step_ab(1'b1, 5'd7, 32'h00005678, 5'd7, 5'd7, 1'b0, 5'd0);
    step_ab(1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd0);

    // Scoreboard: reserve, release, reserve+release collision.
    step_ab(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
    step_ab(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    step_ab(1'b1, 5'd9, 32'h0000AAAA, 5'd9, 5'd0, 1'b0, 5'd0);
    step_ab(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    step_ab(1'b1, 5'd9, 32'h0000BBBB, 5'd0, 5'd9, 1'b1, 5'd9);
    step_ab(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9);
    step_ab(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd0);

    repeat (400) rand_ab();

    // Reset in the middle of INIT restarts the full sequence and drops pending flags.
    step_ab(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd12);
    step_ab(1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 1'b1, 5'd20);
    do_reset(2);
    repeat (9) rand_ab();
    do_reset(2);
    repeat (31) step_ab(1'b0, 5'd0, 32'h0, 5'd12, 5'd20, 1'b0, 5'd0);
    step_ab(1'b0, 5'd0, 32'h0, 5'd12, 5'd20, 1'b0, 5'd0);
    repeat (100) rand_ab();

    // Wide, three-port instance.
    step_c(1'b1, 4'd3, 64'h0123456789ABCDEF, 12'h0, 1'b0, 4'd0);
    step_c(1'b1, 4'd4, 64'hFEDCBA9876543210, 12'h0, 1'b0, 4'd0);
    step_c(1'b1, 4'd15, 64'h5A5A5A5AA5A5A5A5, {4'd4, 4'd3, 4'd15}, 1'b1, 4'd3);
    step_c(1'b0, 4'd0, 64'h0, {4'd15, 4'd4, 4'd3}, 1'b0, 4'd0);
    repeat (300) rand_c();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
